// File: rtl/v6_peak_detect_pkg.sv
// ============================================================================
// v6_param : shared types and constants for the v6 peak detector
// Rev 1.0  : initial release
// ============================================================================
`default_nettype none

package v6_param;

    localparam int SIZE_OUT     = 16;
    localparam int PK_TS_W      = 32;
    localparam int PK_WID_W     = 8;
    localparam int PK_MAX_WIDTH = 200;
    localparam int PK_HOLDOFF   = 16;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        TRACK    = 2'd1,
        HOLDOFF  = 2'd2,
        WAIT_LOW = 2'd3
    } pk_state_t;

    // 'time' is a reserved word, so the timestamp field is ptime
    typedef struct packed {
        logic [SIZE_OUT-1:0] amp;
        logic [PK_TS_W-1:0]  ptime;
        logic [PK_WID_W-1:0] width;
        logic                timeout;
    } pk_event_t;

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/v6_peak_evreg.sv
// ============================================================================
// v6_peak_evreg : 1-deep valid/ready event register with saturating drop count
// Rev 1.0       : initial release
// ============================================================================
`default_nettype none

module v6_peak_evreg
    import v6_param::*;
#(
    parameter int DATA_W = SIZE_OUT,
    parameter int TS_W   = PK_TS_W,
    parameter int WID_W  = PK_WID_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              i_load,
    input  logic [DATA_W-1:0] i_amp,
    input  logic [TS_W-1:0]   i_time,
    input  logic [WID_W-1:0]  i_width,
    input  logic              i_timeout,
    input  logic              i_ready,
    output logic              o_valid,
    output logic [DATA_W-1:0] o_amp,
    output logic [TS_W-1:0]   o_time,
    output logic [WID_W-1:0]  o_width,
    output logic              o_timeout,
    output logic [15:0]       o_drop_cnt
);

    logic              r_valid;
    logic [DATA_W-1:0] r_amp;
    logic [TS_W-1:0]   r_time;
    logic [WID_W-1:0]  r_width;
    logic              r_timeout;
    logic [15:0]       r_drop_cnt;
    logic              w_accept;

    // A slot being read out this cycle can take the new event, so back-to-back emits never drop
    assign w_accept = !r_valid || i_ready;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_valid    <= 1'b0;
            r_amp      <= '0;
            r_time     <= '0;
            r_width    <= '0;
            r_timeout  <= 1'b0;
            r_drop_cnt <= '0;
        end else begin
            if (i_load && w_accept) begin
                r_valid   <= 1'b1;
                r_amp     <= i_amp;
                r_time    <= i_time;
                r_width   <= i_width;
                r_timeout <= i_timeout;
            end else if (r_valid && i_ready) begin
                r_valid <= 1'b0;
            end
            if (i_load && !w_accept) begin
                r_drop_cnt <= sat_inc16(r_drop_cnt);
            end
        end
    end

    assign o_valid    = r_valid;
    assign o_amp      = r_amp;
    assign o_time     = r_time;
    assign o_width    = r_width;
    assign o_timeout  = r_timeout;
    assign o_drop_cnt = r_drop_cnt;

endmodule

`default_nettype wire

// File: rtl/v6_peak_detect.sv
// ============================================================================
// v6_peak_detect : pulse peak/time/width extraction on the shaped sample stream
// Optional macro V6_PEAK_PILEUP_EN : count and suppress pulses arriving in holdoff
// Rev 1.0        : initial release
// ============================================================================
`default_nettype none

module v6_peak_detect #(
    parameter int DATA_W    = v6_param::SIZE_OUT,
    parameter int TS_W      = v6_param::PK_TS_W,
    parameter int WID_W     = v6_param::PK_WID_W,
    parameter int MAX_WIDTH = v6_param::PK_MAX_WIDTH,
    parameter int HOLDOFF   = v6_param::PK_HOLDOFF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] data_in,
    input  logic [DATA_W-1:0] threshold,
    input  logic              peak_ready,
    output logic              peak_valid,
    output logic [DATA_W-1:0] peak_amp,
    output logic [TS_W-1:0]   peak_time,
    output logic [WID_W-1:0]  peak_width,
    output logic              peak_timeout,
`ifdef V6_PEAK_PILEUP_EN
    output logic [15:0]       pileup_cnt,
`endif
    output logic [15:0]       drop_cnt
);

    localparam int               HO_W        = (HOLDOFF > 1) ? $clog2(HOLDOFF) : 1;
    localparam logic [HO_W-1:0]  c_ho_last   = HO_W'(HOLDOFF - 1);
    localparam logic [WID_W-1:0] c_max_width = WID_W'(MAX_WIDTH);
    localparam logic [WID_W-1:0] c_wid_sat   = '1;

    v6_param::pk_state_t r_state;
    v6_param::pk_state_t w_state_nxt;

    logic [TS_W-1:0]   r_ts;
    logic [DATA_W-1:0] r_thr;
    logic [DATA_W-1:0] r_max;
    logic [TS_W-1:0]   r_tmax;
    logic [WID_W-1:0]  r_width;
    logic [HO_W-1:0]   r_ho_cnt;
    logic              w_above;
    logic              w_trigger;
    logic              w_emit;
    logic              w_timeout;
`ifdef V6_PEAK_PILEUP_EN
    logic              w_pileup;
    logic [15:0]       r_pileup_cnt;
`endif

    assign w_above   = data_in > r_thr;
    assign w_trigger = data_in > threshold;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= v6_param::IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_emit      = 1'b0;
        w_timeout   = 1'b0;
`ifdef V6_PEAK_PILEUP_EN
        w_pileup    = 1'b0;
`endif
        case (r_state)
            v6_param::IDLE: begin
                if (w_trigger) begin
                    w_state_nxt = v6_param::TRACK;
                end
            end
            v6_param::TRACK: begin
                if (!w_above) begin
                    w_emit      = 1'b1;
                    w_state_nxt = v6_param::HOLDOFF;
                end else if (r_width == c_max_width) begin
                    w_emit      = 1'b1;
                    w_timeout   = 1'b1;
                    w_state_nxt = v6_param::WAIT_LOW;
                end
            end
            v6_param::HOLDOFF: begin
`ifdef V6_PEAK_PILEUP_EN
                if (w_above) begin
                    w_pileup    = 1'b1;
                    w_state_nxt = v6_param::WAIT_LOW;
                end else if (r_ho_cnt == c_ho_last) begin
                    w_state_nxt = v6_param::IDLE;
                end
`else
                if (r_ho_cnt == c_ho_last) begin
                    w_state_nxt = v6_param::IDLE;
                end
`endif
            end
            v6_param::WAIT_LOW: begin
                if (!w_above) begin
                    w_state_nxt = v6_param::HOLDOFF;
                end
            end
            default: w_state_nxt = v6_param::IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_ts     <= '0;
            r_thr    <= '0;
            r_max    <= '0;
            r_tmax   <= '0;
            r_width  <= '0;
            r_ho_cnt <= '0;
        end else begin
            r_ts     <= r_ts + TS_W'(1);
            r_ho_cnt <= (r_state == v6_param::HOLDOFF) ? r_ho_cnt + HO_W'(1) : '0;
            if (r_state == v6_param::IDLE && w_trigger) begin
                r_thr   <= threshold;
                r_max   <= data_in;
                r_tmax  <= r_ts;
                r_width <= WID_W'(1);
            end else if (r_state == v6_param::TRACK && w_above && !w_emit) begin
                // Strict compare keeps the first timestamp of a flat top
                if (data_in > r_max) begin
                    r_max  <= data_in;
                    r_tmax <= r_ts;
                end
                if (r_width != c_wid_sat) begin
                    r_width <= r_width + WID_W'(1);
                end
            end
        end
    end

`ifdef V6_PEAK_PILEUP_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_pileup_cnt <= '0;
        end else if (w_pileup) begin
            r_pileup_cnt <= v6_param::sat_inc16(r_pileup_cnt);
        end
    end

    assign pileup_cnt = r_pileup_cnt;
`endif

    v6_peak_evreg #(
        .DATA_W (DATA_W),
        .TS_W   (TS_W),
        .WID_W  (WID_W)
    ) u_evreg (
        .clk        (clk),
        .reset      (reset),
        .i_load     (w_emit),
        .i_amp      (r_max),
        .i_time     (r_tmax),
        .i_width    (r_width),
        .i_timeout  (w_timeout),
        .i_ready    (peak_ready),
        .o_valid    (peak_valid),
        .o_amp      (peak_amp),
        .o_time     (peak_time),
        .o_width    (peak_width),
        .o_timeout  (peak_timeout),
        .o_drop_cnt (drop_cnt)
    );

endmodule

`default_nettype wire

// File: tb/tb_v6_peak_detect.sv
// ============================================================================
// tb_v6_peak_detect : scoreboard bench for v6_peak_detect (both macro builds)
// Rev 1.0           : initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_v6_peak_detect;

    logic        clk        = 1'b0;
    logic        reset      = 1'b0;
    logic [15:0] data_in    = '0;
    logic [15:0] threshold  = '0;
    logic        peak_ready = 1'b0;
    logic        peak_valid;
    logic [15:0] peak_amp;
    logic [31:0] peak_time;
    logic [7:0]  peak_width;
    logic        peak_timeout;
    logic [15:0] drop_cnt;
`ifdef V6_PEAK_PILEUP_EN
    logic [15:0] pileup_cnt;
`endif

    typedef struct packed {
        logic [15:0] amp;
        logic [31:0] t;
        logic [7:0]  w;
        logic        to;
    } ev_t;

    ev_t exp_q[$];
    ev_t mon_e;
    int  n_tests = 0;
    int  n_fail  = 0;

    always #5 clk = ~clk;

    v6_peak_detect dut (
        .clk          (clk),
        .reset        (reset),
        .data_in      (data_in),
        .threshold    (threshold),
        .peak_ready   (peak_ready),
        .peak_valid   (peak_valid),
        .peak_amp     (peak_amp),
        .peak_time    (peak_time),
        .peak_width   (peak_width),
        .peak_timeout (peak_timeout),
`ifdef V6_PEAK_PILEUP_EN
        .pileup_cnt   (pileup_cnt),
`endif
        .drop_cnt     (drop_cnt)
    );

    // Scoreboard: every transfer pops the oldest expected event
    always @(negedge clk) begin
        if (reset && peak_valid && peak_ready) begin
            n_tests++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_event amp=%0d time=%0d width=%0d to=%0b",
                         peak_amp, peak_time, peak_width, peak_timeout);
            end else begin
                mon_e = exp_q.pop_front();
                if ({peak_amp, peak_time, peak_width, peak_timeout} !== mon_e) begin
                    n_fail++;
                    $display("FAIL event got amp=%0d time=%0d width=%0d to=%0b want amp=%0d time=%0d width=%0d to=%0b",
                             peak_amp, peak_time, peak_width, peak_timeout,
                             mon_e.amp, mon_e.t, mon_e.w, mon_e.to);
                end
            end
        end
    end

    task automatic send(input logic [15:0] v);
        data_in = v;
        @(posedge clk);
        #1;
    endtask

    task automatic send_n(input logic [15:0] v, input int n);
        repeat (n) send(v);
    endtask

    // After this returns, the next clock edge samples the ts=0 sample
    task automatic do_reset();
        reset   = 1'b0;
        data_in = '0;
        @(posedge clk);
        #1;
        reset = 1'b1;
    endtask

    task automatic check_drained(input string name);
        n_tests++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL %s_drained pending=%0d want 0", name, exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic test_reset();
        reset      = 1'b0;
        threshold  = 16'd100;
        peak_ready = 1'b0;
        data_in    = 16'd500;
        repeat (2) @(posedge clk);
        #1;
        n_tests++;
        if ({peak_valid, peak_amp, peak_time, peak_width, peak_timeout, drop_cnt} !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs valid=%0b amp=%0d time=%0d width=%0d to=%0b drop=%0d want all 0",
                     peak_valid, peak_amp, peak_time, peak_width, peak_timeout, drop_cnt);
        end
    endtask

    task automatic test_ramp();
        logic [15:0] ramp [5] = '{16'd0, 16'd50, 16'd150, 16'd300, 16'd200};
        do_reset();
        threshold  = 16'd100;
        peak_ready = 1'b1;
        exp_q.push_back('{amp: 16'd300, t: 32'd3, w: 8'd3, to: 1'b0});
        foreach (ramp[i]) send(ramp[i]);
        n_tests++;
        if (peak_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL ramp_early_valid valid=%0b want 0", peak_valid);
        end
        send(16'd90);
        n_tests++;
        if (peak_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL ramp_latency valid=%0b want 1", peak_valid);
        end
        send_n(16'd0, 20);
        check_drained("ramp");
    endtask

    task automatic test_plateau();
        do_reset();
        threshold  = 16'd100;
        peak_ready = 1'b1;
        exp_q.push_back('{amp: 16'd300, t: 32'd2, w: 8'd3, to: 1'b0});
        send(16'd0);
        send(16'd150);
        send(16'd300);
        send(16'd300);
        send(16'd80);
        send_n(16'd0, 20);
        check_drained("plateau");
    endtask

    task automatic test_timeout();
        do_reset();
        threshold  = 16'd100;
        peak_ready = 1'b1;
        exp_q.push_back('{amp: 16'd500, t: 32'd0, w: 8'd200, to: 1'b1});
        send_n(16'd500, 200);
        n_tests++;
        if (peak_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL timeout_early valid=%0b want 0", peak_valid);
        end
        send(16'd500);
        n_tests++;
        if (peak_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL timeout_emit valid=%0b want 1", peak_valid);
        end
        send_n(16'd500, 49);
        check_drained("timeout_first");
        n_tests++;
        if (peak_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL timeout_waitlow_event valid=%0b want 0", peak_valid);
        end
        // Low at ts=250, 16 holdoff samples, retrigger on the first idle sample ts=267
        send(16'd50);
        send_n(16'd0, 16);
        exp_q.push_back('{amp: 16'd500, t: 32'd267, w: 8'd1, to: 1'b0});
        send(16'd500);
        send(16'd0);
        send_n(16'd0, 5);
        check_drained("timeout_retrigger");
    endtask

    task automatic test_backpressure();
        do_reset();
        threshold  = 16'd100;
        peak_ready = 1'b0;
        send(16'd0);
        send(16'd200);
        send(16'd50);
        send_n(16'd0, 22);
        send(16'd300);
        send(16'd50);
        send_n(16'd0, 23);
        send(16'd400);
        send(16'd50);
        send_n(16'd0, 5);
        n_tests++;
        if ({peak_valid, peak_amp, peak_time, peak_width, peak_timeout} !== {1'b1, 16'd200, 32'd1, 8'd1, 1'b0}) begin
            n_fail++;
            $display("FAIL bp_held valid=%0b amp=%0d time=%0d width=%0d to=%0b want 1/200/1/1/0",
                     peak_valid, peak_amp, peak_time, peak_width, peak_timeout);
        end
        n_tests++;
        if (drop_cnt !== 16'd2) begin
            n_fail++;
            $display("FAIL bp_drop_cnt got=%0d want 2", drop_cnt);
        end
        exp_q.push_back('{amp: 16'd200, t: 32'd1, w: 8'd1, to: 1'b0});
        peak_ready = 1'b1;
        send(16'd0);
        peak_ready = 1'b0;
        n_tests++;
        if (peak_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL bp_release valid=%0b want 0", peak_valid);
        end
        check_drained("bp");
    endtask

    task automatic test_pileup();
        do_reset();
        threshold  = 16'd100;
        peak_ready = 1'b1;
        exp_q.push_back('{amp: 16'd200, t: 32'd0, w: 8'd1, to: 1'b0});
`ifndef V6_PEAK_PILEUP_EN
        // Holdoff covers ts 2..17; the still-high input retriggers at ts=18
        exp_q.push_back('{amp: 16'd250, t: 32'd18, w: 8'd7, to: 1'b0});
`endif
        send(16'd200);
        send(16'd50);
        send_n(16'd0, 5);
        send_n(16'd250, 18);
        send(16'd50);
        send_n(16'd0, 20);
        check_drained("pileup");
`ifdef V6_PEAK_PILEUP_EN
        n_tests++;
        if (pileup_cnt !== 16'd1) begin
            n_fail++;
            $display("FAIL pileup_cnt got=%0d want 1", pileup_cnt);
        end
`endif
    endtask

    task automatic test_async_reset();
        do_reset();
        threshold  = 16'd100;
        peak_ready = 1'b0;
        send(16'd200);
        send(16'd50);
        send_n(16'd0, 18);
        send(16'd300);
        send(16'd350);
        #2;
        reset = 1'b0;
        #1;
        n_tests++;
        if ({peak_valid, peak_amp, peak_time, peak_width, peak_timeout, drop_cnt} !== '0) begin
            n_fail++;
            $display("FAIL async_reset valid=%0b amp=%0d time=%0d width=%0d to=%0b drop=%0d want all 0",
                     peak_valid, peak_amp, peak_time, peak_width, peak_timeout, drop_cnt);
        end
        @(posedge clk);
        #1;
        reset      = 1'b1;
        peak_ready = 1'b1;
        exp_q.push_back('{amp: 16'd180, t: 32'd1, w: 8'd1, to: 1'b0});
        send(16'd0);
        send(16'd180);
        send(16'd60);
        send_n(16'd0, 5);
        check_drained("after_reset");
    endtask

    initial begin
        test_reset();
        test_ramp();
        test_plateau();
        test_timeout();
        test_backpressure();
        test_pileup();
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
